// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_sub
// Description : Bit-serial 8-bit adder/subtractor. A single full adder and a
//               registered carry process one bit pair per cycle, LSB first.
//               The result shifts into sum from the MSB side. Sum, carry_out
//               and overflow hold their values from DONE until the next
//               accepted start.
// Revision    : 1.0 - initial release
//
// Configuration macro:
//   SERIAL_SUB_EN  - when defined, op_sub=1 computes x + ~y + 1.
//                    When undefined, op_sub is ignored and the block always
//                    computes x + y + carry_in.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   start      in   1  request a new operation (accepted in IDLE or DONE)
//   op_sub     in   1  0 = add, 1 = subtract (only with SERIAL_SUB_EN)
//   x          in   8  operand A
//   y          in   8  operand B
//   carry_in   in   1  carry into bit 0 in add mode
//   busy       out  1  high during the 8 SHIFT cycles
//   done       out  1  single-cycle completion pulse
//   sum        out  8  result
//   carry_out  out  1  carry out of bit 7 (subtract: 1 = no borrow)
//   overflow   out  1  signed overflow (carry into bit 7 ^ carry out)
// ============================================================================
module serial_add_sub (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       op_sub,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       carry_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] sum,
  output logic       carry_out,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  // Operands are latched on the accepting edge; SHIFT begins on the edge
  // after that. pending marks that one-cycle gap so the FSM keeps exactly
  // three states while still meeting the start-to-done latency.
  logic       pending;
  logic [7:0] x_reg;
  logic [7:0] y_reg;
  logic       carry_reg;
  logic [2:0] bit_cnt;

  logic       accept;
  logic [7:0] y_load;
  logic       carry_load;
  logic       fa_sum;
  logic       fa_carry;
  logic       last_bit;

  // A start while an operation is pending or shifting is ignored.
  assign accept = start && (((state == IDLE) && !pending) || (state == DONE));

`ifdef SERIAL_SUB_EN
  // Subtraction as x + ~y + 1: invert y at load and seed the carry with 1.
  assign y_load     = op_sub ? ~y : y;
  assign carry_load = op_sub ? 1'b1 : carry_in;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign y_load        = y;
  assign carry_load    = carry_in;
`endif

  assign fa_sum   = x_reg[0] ^ y_reg[0] ^ carry_reg;
  assign fa_carry = (x_reg[0] & y_reg[0]) | (x_reg[0] & carry_reg) |
                    (y_reg[0] & carry_reg);
  assign last_bit = (bit_cnt == 3'd7);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (pending) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      // DONE always lasts one cycle; an accepted start goes through the
      // pending gap in IDLE so done cannot pulse twice in a row.
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 1'b0;
      x_reg     <= 8'd0;
      y_reg     <= 8'd0;
      carry_reg <= 1'b0;
      bit_cnt   <= 3'd0;
      sum       <= 8'd0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= accept;
      if (accept) begin
        x_reg     <= x;
        y_reg     <= y_load;
        carry_reg <= carry_load;
        bit_cnt   <= 3'd0;
      end else if (state == SHIFT) begin
        sum       <= {fa_sum, sum[7:1]};
        x_reg     <= {1'b0, x_reg[7:1]};
        y_reg     <= {1'b0, y_reg[7:1]};
        carry_reg <= fa_carry;
        bit_cnt   <= bit_cnt + 3'd1;
        if (last_bit) begin
          carry_out <= fa_carry;
          // carry_reg here is the carry into bit 7.
          overflow  <= fa_carry ^ carry_reg;
        end
      end
    end
  end

endmodule
`default_nettype wire
